// File: rtl/cm_notif_tx_pkg.sv
// Shared constants, FSM encoding and frame payload type for the CM UART notification transmitter.
// The checksum feature is built with CM_TX_CHECKSUM_EN defined.
package cm_notif_tx_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned NUM_SRC = 3;

    // Slot indices inside the per-source vectors
    localparam int unsigned SLOT_CFG = 0;
    localparam int unsigned SLOT_ERR = 1;
    localparam int unsigned SLOT_VGA = 2;

    localparam logic [1:0] HDR_MARK = 2'b10;
    localparam logic [1:0] ID_CFG   = 2'b01;
    localparam logic [1:0] ID_ERR   = 2'b10;
    localparam logic [1:0] ID_VGA   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CHK  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [1:0]        id;
        logic              ovf;
        logic [CODE_W-1:0] code;
    } frame_t;

    function automatic logic [BYTE_W-1:0] hdr_byte(input frame_t f);
        return {HDR_MARK, f.id, f.ovf, 3'b000};
    endfunction

    function automatic logic [BYTE_W-1:0] pay_byte(input frame_t f);
        return {4'b0000, f.code};
    endfunction

endpackage

// File: rtl/cm_notif_slot.sv
// One pending-event slot: holds the latest code of a source, its pending bit and an overwrite flag.
module cm_notif_slot
    import cm_notif_tx_pkg::*;
#(
    parameter int unsigned IN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe,
    input  logic [IN_W-1:0]   code_in,
    input  logic              consume,
    output logic              pending,
    output logic [CODE_W-1:0] code,
    output logic              ovf,
    output logic              overwrite_c
);

    // A strobe in the consume cycle starts a fresh event: the old one is being sent, not lost
    assign overwrite_c = strobe & pending & ~consume;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pending <= 1'b0;
            code    <= '0;
            ovf     <= 1'b0;
        end else if (strobe) begin
            pending <= 1'b1;
            code    <= CODE_W'(code_in);
            ovf     <= (ovf | pending) & ~consume;
        end else if (consume) begin
            pending <= 1'b0;
            ovf     <= 1'b0;
        end
    end

endmodule

// File: rtl/cm_notif_tx.sv
// CM UART TX notifier: captures status strobes into slots, arbitrates and frames them into the TX FIFO.
// Define CM_TX_CHECKSUM_EN to append a header^payload checksum byte to every frame.
module cm_notif_tx
    import cm_notif_tx_pkg::*;
#(
    parameter int unsigned UART_DATA_WIDTH           = 8,
    parameter int unsigned CONFIG_NOTIFICATION_WIDTH = 4,
    parameter int unsigned CONFIG_ERROR_WIDTH        = 4,
    parameter int unsigned VGA_NOTIFICATION_WIDTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
    input  logic                                 Config_Notification_Valid,
    input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
    input  logic                                 Error_Valid,
    input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
    input  logic                                 VGA_Notification_Valid,
    input  logic                                 Full,
    output logic [UART_DATA_WIDTH-1:0]           TXD_Data,
    output logic                                 TXD_Wr,
    output logic                                 Tx_Busy,
    output logic                                 Tx_Overflow
);

    tx_state_e           state;
    tx_state_e           state_nxt;
    logic [NUM_SRC-1:0]  pend;
    logic [NUM_SRC-1:0]  slot_ovf;
    logic [NUM_SRC-1:0]  overwrite;
    logic [NUM_SRC-1:0]  consume;
    logic [CODE_W-1:0]   slot_code [NUM_SRC];
    frame_t              frame;
    frame_t              winner;
    logic                load;
    logic [BYTE_W-1:0]   data_q;
    logic [BYTE_W-1:0]   data_nxt;

    cm_notif_slot #(.IN_W(CONFIG_NOTIFICATION_WIDTH)) u_slot_cfg (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe      (Config_Notification_Valid),
        .code_in     (Config_Notification),
        .consume     (consume[SLOT_CFG]),
        .pending     (pend[SLOT_CFG]),
        .code        (slot_code[SLOT_CFG]),
        .ovf         (slot_ovf[SLOT_CFG]),
        .overwrite_c (overwrite[SLOT_CFG])
    );

    cm_notif_slot #(.IN_W(CONFIG_ERROR_WIDTH)) u_slot_err (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe      (Error_Valid),
        .code_in     (Config_Error),
        .consume     (consume[SLOT_ERR]),
        .pending     (pend[SLOT_ERR]),
        .code        (slot_code[SLOT_ERR]),
        .ovf         (slot_ovf[SLOT_ERR]),
        .overwrite_c (overwrite[SLOT_ERR])
    );

    cm_notif_slot #(.IN_W(VGA_NOTIFICATION_WIDTH)) u_slot_vga (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe      (VGA_Notification_Valid),
        .code_in     (VGA_Notification),
        .consume     (consume[SLOT_VGA]),
        .pending     (pend[SLOT_VGA]),
        .code        (slot_code[SLOT_VGA]),
        .ovf         (slot_ovf[SLOT_VGA]),
        .overwrite_c (overwrite[SLOT_VGA])
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|pend) state_nxt = ST_HDR;
            ST_HDR:  if (!Full) state_nxt = ST_PAY;
`ifdef CM_TX_CHECKSUM_EN
            ST_PAY:  if (!Full) state_nxt = ST_CHK;
`else
            ST_PAY:  if (!Full) state_nxt = ST_IDLE;
`endif
            ST_CHK:  if (!Full) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration, write strobe and the next byte to present; reset silences everything at once
    always_comb begin
        TXD_Wr   = 1'b0;
        Tx_Busy  = |pend;
        consume  = '0;
        load     = 1'b0;
        winner   = '0;
        data_nxt = data_q;
        case (state)
            ST_IDLE: begin
                if (|pend) begin
                    load = 1'b1;
                    if (pend[SLOT_ERR]) begin
                        winner.id         = ID_ERR;
                        winner.ovf        = slot_ovf[SLOT_ERR];
                        winner.code       = slot_code[SLOT_ERR];
                        consume[SLOT_ERR] = 1'b1;
                    end else if (pend[SLOT_CFG]) begin
                        winner.id         = ID_CFG;
                        winner.ovf        = slot_ovf[SLOT_CFG];
                        winner.code       = slot_code[SLOT_CFG];
                        consume[SLOT_CFG] = 1'b1;
                    end else begin
                        winner.id         = ID_VGA;
                        winner.ovf        = slot_ovf[SLOT_VGA];
                        winner.code       = slot_code[SLOT_VGA];
                        consume[SLOT_VGA] = 1'b1;
                    end
                    data_nxt = hdr_byte(winner);
                end
            end
            ST_HDR: begin
                Tx_Busy = 1'b1;
                TXD_Wr  = !Full;
                if (!Full) data_nxt = pay_byte(frame);
            end
            ST_PAY: begin
                Tx_Busy = 1'b1;
                TXD_Wr  = !Full;
`ifdef CM_TX_CHECKSUM_EN
                if (!Full) data_nxt = hdr_byte(frame) ^ pay_byte(frame);
`else
                if (!Full) data_nxt = '0;
`endif
            end
            ST_CHK: begin
                Tx_Busy = 1'b1;
                TXD_Wr  = !Full;
                if (!Full) data_nxt = '0;
            end
            default: ;
        endcase
        if (rst_n) begin
            TXD_Wr  = 1'b0;
            Tx_Busy = 1'b0;
            consume = '0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_q      <= '0;
            frame       <= '0;
            Tx_Overflow <= 1'b0;
        end else begin
            data_q      <= data_nxt;
            Tx_Overflow <= Tx_Overflow | (|overwrite);
            if (load) frame <= winner;
        end
    end

    assign TXD_Data = UART_DATA_WIDTH'(data_q);

endmodule
